// File: rtl/nibble_serial_adder_16.sv
// Nibble-serial W-bit adder: drives one nibble per cycle through an external
// combinational 4-bit adder and returns the registered sum, carry and overflow.
module nibble_serial_adder_16 #(
  parameter int N_NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*N_NIBBLES-1:0] A,
  input  logic [4*N_NIBBLES-1:0] B,
  input  logic                   Cin,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [3:0]             Add_A,
  output logic [3:0]             Add_B,
  output logic                   Add_Cin,
  input  logic [3:0]             Add_Sum,
  input  logic                   Add_Cout,
  output logic [4*N_NIBBLES-1:0] Sum,
  output logic                   Cout,
  output logic                   Ovf,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int W     = 4 * N_NIBBLES;
  localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               cin_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic [IDX_W+1:0]   bit_base_s;

  assign bit_base_s = {idx_r, 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = ADD;
        else          state_s = IDLE;
      end
      ADD: begin
        if (idx_r == LAST_IDX) state_s = DONE;
        else                   state_s = ADD;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake flags and external adder operands, all zero outside ADD
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    Add_A     = 4'd0;
    Add_B     = 4'd0;
    Add_Cin   = 1'b0;
    if (state_r == ADD) begin
      Add_A   = a_r[bit_base_s +: 4];
      Add_B   = b_r[bit_base_s +: 4];
      Add_Cin = (idx_r == '0) ? cin_r : carry_r;
    end else begin
      in_ready  = (state_r == IDLE);
      out_valid = (state_r == DONE);
    end
  end

  // Operand latch, nibble sequencing and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      cin_r   <= 1'b0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= A;
            b_r   <= B;
            cin_r <= Cin;
            idx_r <= '0;
          end
        end
        ADD: begin
          sum_r[bit_base_s +: 4] <= Add_Sum;
          carry_r                <= Add_Cout;
          if (idx_r == LAST_IDX) begin
            idx_r  <= '0;
            cout_r <= Add_Cout;
            // The top nibble's Add_Sum[3] is the final sign bit of the result
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (Add_Sum[3] != a_r[W-1]);
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign Sum  = sum_r;
  assign Cout = cout_r;
  assign Ovf  = ovf_r;

endmodule

// File: doc/nibble_serial_adder_16.md
NIBBLE_SERIAL_ADDER_16 -- requirements
Module: nibble_serial_adder_16

Interface
REQ-001 Parameter N_NIBBLES, default 4, SHALL set the number of 4-bit nibbles per operand; operand width W = 4*N_NIBBLES; legal range 2..8.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 A  input  W  SHALL be operand A, sampled only on the input handshake.
REQ-005 B  input  W  SHALL be operand B, sampled only on the input handshake.
REQ-006 Cin  input  1  SHALL be the carry-in, sampled only on the input handshake.
REQ-007 in_valid  input  1  SHALL indicate that A/B/Cin are valid.
REQ-008 in_ready  output  1  SHALL indicate that the block can accept operands.
REQ-009 Add_A  output  4  SHALL drive operand A of the external combinational 4-bit adder.
REQ-010 Add_B  output  4  SHALL drive operand B of the external 4-bit adder.
REQ-011 Add_Cin  output  1  SHALL drive carry-in of the external 4-bit adder.
REQ-012 Add_Sum  input  4  SHALL carry the sum returned by the external adder in the same cycle.
REQ-013 Add_Cout  input  1  SHALL carry the carry-out returned by the external adder in the same cycle.
REQ-014 Sum  output  W  SHALL hold the registered W-bit result.
REQ-015 Cout  output  1  SHALL hold the registered final carry-out.
REQ-016 Ovf  output  1  SHALL hold the registered two's-complement overflow flag.
REQ-017 out_valid  output  1  SHALL indicate that Sum/Cout/Ovf are valid.
REQ-018 out_ready  input  1  SHALL indicate that the consumer accepts the result.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-020 IDLE: in_ready=1 and out_valid=0; when in_valid=1 at the edge, the block SHALL latch A, B and Cin, clear the nibble index to 0, and enter ADD.
REQ-021 ADD: in_ready=0; Add_A and Add_B SHALL equal nibble idx of the latched A and B, where nibble idx is bits [4*idx+3 : 4*idx].
REQ-022 ADD: Add_Cin SHALL equal the latched Cin when idx=0, and the internal carry register otherwise.
REQ-023 At each ADD edge, the block SHALL write Add_Sum into Sum nibble idx, write Add_Cout into the carry register, and increment idx.
REQ-024 At the ADD edge with idx=N_NIBBLES-1, the block SHALL also load Cout<=Add_Cout, compute Ovf, and enter DONE; idx SHALL wrap to 0.
REQ-025 Ovf SHALL be (A[W-1]==B[W-1]) && (final Sum[W-1]!=A[W-1]), evaluated on the latched operands.
REQ-026 Latency: out_valid SHALL rise exactly N_NIBBLES clocks after the input-handshake edge, i.e. 4 clocks at the default.
REQ-027 DONE: out_valid=1; Sum, Cout and Ovf SHALL stay stable until out_ready=1 at an edge, after which the FSM SHALL enter IDLE.
REQ-028 Back-to-back transfers SHALL NOT occur: in_ready SHALL be 0 in DONE, even in the cycle where out_ready=1.
REQ-029 In IDLE and DONE, Add_A, Add_B and Add_Cin SHALL be driven to 0.
REQ-030 in_valid SHALL be ignored outside IDLE, and the latched operands SHALL NOT change.
REQ-031 Sum, Cout and Ovf SHALL retain the last result in IDLE; only a new ADD sequence SHALL overwrite them.
REQ-032 Partial Sum nibbles SHALL be visible during ADD but are undefined for consumers; only out_valid qualifies Sum, Cout and Ovf.

Reset
REQ-033 With reset=1 at an edge: state=IDLE, idx=0, carry register=0, Sum=0, Cout=0, Ovf=0, out_valid=0, in_ready=1.
REQ-034 Reset SHALL take priority over every handshake; an in-flight ADD or DONE SHALL be discarded with no output handshake.
REQ-035 If in_valid=1 together with reset=1, the operands SHALL NOT be accepted.

Verification
REQ-036 A=0x1234, B=0x4321, Cin=0 -> after 4 clocks Sum=0x5555, Cout=0, Ovf=0; Add_A sequence shall be 4,3,2,1.
REQ-037 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0; Add_Cin shall be 0,1,1,1 across the ADD cycles.
REQ-038 A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1; then A=0x00FF, B=0x0000, Cin=1 -> Sum=0x0100, Cout=0.
REQ-039 Hold out_ready=0 for 3 clocks in DONE and pulse in_valid -> Sum, Cout, Ovf and out_valid stay stable, in_ready=0, and no new operands are latched.
REQ-040 Assert reset for 1 clock at idx=2 in ADD -> the next cycle shows out_valid=0, in_ready=1, Sum=0; a following A=0x0001, B=0x0001 gives Sum=0x0002.
REQ-041 Bench SHALL close the loop with a combinational 4-bit adder model (Add_Sum/Add_Cout = Add_A+Add_B+Add_Cin) and compare against random 16-bit reference sums (at least 1000 vectors).
